dnpcie_aurora_txframer: RTL and testbench
=========================================

// Module: dnpcie_aurora_txframer
// PURPOSE
//  Store-and-forward TX frame buffer in front of the Aurora TX CRC stage (16b AXI4-Stream, [0:15]/[0:1] ordering).
//  Releases a frame downstream only once it is completely stored, so the CRC stage never sees mid-frame gaps.
//  Drops oversize frames and flushes on link loss.
// PARAMETERS
//  ADDR_W          6   log2 buffer depth in words (depth 64)
//  MAX_FRAME_WORDS 32  max accepted frame length in words; must be < 2**ADDR_W
// PORTS
//  aclk            in   1      clock, single domain
//  reset           in   1      synchronous, active-high reset
//  channel_up      in   1      Aurora channel status
//  s_axis_tdata    in   [0:15] frame data in
//  s_axis_tkeep    in   [0:1]  byte keep; only {1,1} or {1,0} (last word only) legal
//  s_axis_tlast    in   1      end of frame
//  s_axis_tvalid   in   1      input valid
//  s_axis_tready   out  1      input ready
//  m_axis_tdata    out  [0:15] to TX CRC stage
//  m_axis_tkeep    out  [0:1]
//  m_axis_tlast    out  1
//  m_axis_tvalid   out  1
//  m_axis_tready   in   1
//  frames_pending  out  [ADDR_W:0] committed frames not yet fully sent
// BEHAVIOUR
//  Reset: m_axis_tvalid=0, tdata/tkeep/tlast=0, frames_pending=0, pointers=0, write FSM=IDLE, s_axis_tready=0 during reset.
//  Memory: 2**ADDR_W x 19b {tdata,tkeep,tlast}; wr_ptr, commit_ptr, rd_ptr are ADDR_W+1 bits with wrap bit.
//  full = (wr_ptr - rd_ptr) == 2**ADDR_W; s_axis_tready = !full when channel_up, 1 when !channel_up (sink).
//  Write FSM:
//   IDLE:    accepted beat -> write, len=1; tlast -> commit (commit_ptr<=wr_ptr+1), stay IDLE; else -> STORE.
//   STORE:   accepted beat -> write, len++; tlast -> commit, IDLE.
//            Beat making len > MAX_FRAME_WORDS -> not written, wr_ptr<=commit_ptr (rewind) -> DISCARD (or stay IDLE if that beat has tlast).
//   DISCARD: accept and drop beats; tlast -> IDLE.
//  Beats accepted only on s_axis_tvalid & s_axis_tready; full stalls (backpressure), never drops.
//   MAX_FRAME_WORDS < depth guarantees no deadlock.
//  Read: rd_ptr advances only while rd_ptr != commit_ptr; one-word output register plus prefetch; no bubbles between committed words.
//  Latency: tlast of a 1-word frame accepted at cycle N with output idle -> m_axis_tvalid=1 at N+2.
//  Output data/keep/last held stable while m_axis_tvalid & !m_axis_tready.
//  frames_pending: +1 on commit, -1 on output beat with tlast accepted; both same cycle -> unchanged.
//  Commit and write to same address same cycle: commit visible to read side next cycle (no bypass).
//  channel_up low (sampled): next cycle wr_ptr=commit_ptr=rd_ptr=0, frames_pending=0, m_axis_tvalid=0.
//   Write FSM -> DISCARD if mid-frame, else IDLE; all input discarded while low.
//  channel_up rise mid-frame: remainder of that frame discarded; storing resumes at next frame start.
//  Reset mid-operation: identical to reset values next cycle, regardless of handshake state.
// CONFIGURATION
//  DNPCIE_AURORA_TXFRAMER_STATS_EN defined:
//   adds output drop_count [15:0]; +1 per frame dropped (oversize or flushed by channel_up low),
//   saturates at 16'hFFFF; cleared by reset only.
//  Undefined: port and counter absent; drop behaviour identical.
// TESTING
//  3-word frame A1,A2,A3 (tlast on A3), m_axis_tready=1 -> same 3 words out contiguous, tvalid at N+2 after A3, tlast on A3.
//  Frame of MAX_FRAME_WORDS+1=33 words then 2-word frame B -> only B emitted; frames_pending peaks 1; drop_count=1 (STATS_EN).
//  m_axis_tready=0, push 64 one-word frames -> s_axis_tready=0 after 64th; release tready -> all 64 out in order, frames_pending 64->0.
//  channel_up drop while frame 2 of 3 mid-output -> tvalid=0 next cycle, frames_pending=0, no further output until new frame after rise.
//  Last word tkeep=2'b10, output stalled 5 cycles -> tdata/tkeep/tlast stable throughout, tkeep=2'b10 delivered.
//  Reset asserted mid-frame (in and out) -> all outputs at reset values next cycle; subsequent frame passes intact.

Source files
------------

// File: rtl/dnpcie_aurora_txframer.sv
// Store-and-forward TX frame buffer ahead of the Aurora TX CRC stage; frames leave only once fully stored.
// Optional drop counter output enabled by defining DNPCIE_AURORA_TXFRAMER_STATS_EN.
module dnpcie_aurora_txframer #(
    parameter int unsigned ADDR_W          = 6,
    parameter int unsigned MAX_FRAME_WORDS = 32
) (
    input  logic            aclk,
    input  logic            reset,
    input  logic            channel_up,
    input  logic [0:15]     s_axis_tdata,
    input  logic [0:1]      s_axis_tkeep,
    input  logic            s_axis_tlast,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [0:15]     m_axis_tdata,
    output logic [0:1]      m_axis_tkeep,
    output logic            m_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [ADDR_W:0] frames_pending
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
    ,
    output logic [15:0]     drop_count
`endif
);
    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam int unsigned PTR_W   = ADDR_W + 1;
    localparam int unsigned LEN_W   = $clog2(MAX_FRAME_WORDS + 1);
    localparam int unsigned ENTRY_W = 19;

    typedef enum logic [1:0] {IDLE, STORE, DISCARD} wr_state_t;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   commit_ptr;
    logic [PTR_W-1:0]   fetch_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    wr_state_t          wr_state;
    logic [LEN_W-1:0]   len;
    logic [ENTRY_W-1:0] fetch_word;
    logic               full;
    logic               in_fire;
    logic               out_fire;
    logic               out_last_fire;
    logic               oversize;
    logic               wr_en;
    logic               commit;
    logic               load;

    // rd_ptr retires words only when accepted downstream, so the output register still occupies buffer space
    assign full          = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
    assign s_axis_tready = !reset && (!channel_up || !full);
    assign in_fire       = s_axis_tvalid && s_axis_tready;
    assign out_fire      = m_axis_tvalid && m_axis_tready;
    assign out_last_fire = out_fire && m_axis_tlast;
    assign oversize      = (wr_state == STORE) && (len == LEN_W'(MAX_FRAME_WORDS));
    assign wr_en         = in_fire && channel_up &&
                           ((wr_state == IDLE) || ((wr_state == STORE) && !oversize));
    assign commit        = wr_en && s_axis_tlast;
    assign load          = (!m_axis_tvalid || m_axis_tready) && (fetch_ptr != commit_ptr);
    assign fetch_word    = mem[fetch_ptr[ADDR_W-1:0]];

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast};
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            fetch_ptr      <= '0;
            rd_ptr         <= '0;
            wr_state       <= IDLE;
            len            <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tdata   <= '0;
            m_axis_tkeep   <= '0;
            m_axis_tlast   <= 1'b0;
            frames_pending <= '0;
        end else if (!channel_up) begin
            // Link loss flushes everything; input framing is still tracked so a resumed frame tail is dropped
            wr_ptr         <= '0;
            commit_ptr     <= '0;
            fetch_ptr      <= '0;
            rd_ptr         <= '0;
            len            <= '0;
            m_axis_tvalid  <= 1'b0;
            frames_pending <= '0;
            if (in_fire) begin
                wr_state <= s_axis_tlast ? IDLE : DISCARD;
            end else if (wr_state != IDLE) begin
                wr_state <= DISCARD;
            end
        end else begin
            if (in_fire) begin
                case (wr_state)
                    IDLE: begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        len    <= LEN_W'(1);
                        if (s_axis_tlast) begin
                            commit_ptr <= wr_ptr + PTR_W'(1);
                        end else begin
                            wr_state <= STORE;
                        end
                    end
                    STORE: begin
                        if (oversize) begin
                            wr_ptr   <= commit_ptr;
                            wr_state <= s_axis_tlast ? IDLE : DISCARD;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            len    <= len + LEN_W'(1);
                            if (s_axis_tlast) begin
                                commit_ptr <= wr_ptr + PTR_W'(1);
                                wr_state   <= IDLE;
                            end
                        end
                    end
                    DISCARD: begin
                        if (s_axis_tlast) begin
                            wr_state <= IDLE;
                        end
                    end
                    default: wr_state <= IDLE;
                endcase
            end

            if (load) begin
                {m_axis_tdata, m_axis_tkeep, m_axis_tlast} <= fetch_word;
                m_axis_tvalid <= 1'b1;
                fetch_ptr     <= fetch_ptr + PTR_W'(1);
            end else if (out_fire) begin
                m_axis_tvalid <= 1'b0;
            end

            if (out_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (commit && !out_last_fire) begin
                frames_pending <= frames_pending + PTR_W'(1);
            end else if (!commit && out_last_fire) begin
                frames_pending <= frames_pending - PTR_W'(1);
            end
        end
    end

`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
    logic [PTR_W:0] flush_drops;
    logic [PTR_W:0] drop_inc;
    logic [16:0]    drop_sum;

    // A flush loses every committed frame not fully sent plus any frame being stored
    assign flush_drops = (PTR_W+1)'(frames_pending) - (PTR_W+1)'(out_last_fire)
                       + (PTR_W+1)'(wr_state == STORE);
    assign drop_inc    = !channel_up ? flush_drops : (PTR_W+1)'(in_fire && oversize);
    assign drop_sum    = 17'(drop_count) + 17'(drop_inc);

    always_ff @(posedge aclk) begin
        if (reset) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_dnpcie_aurora_txframer.sv
// Bench for dnpcie_aurora_txframer: frame-length table, hand-written corner sequences and random traffic vs a queue model.
module tb_dnpcie_aurora_txframer;
    localparam int unsigned ADDR_W = 6;
    localparam int          DEPTH  = 64;
    localparam int          MAXW   = 32;

    logic            aclk = 1'b0;
    logic            rst;
    logic            cu;
    logic            in_valid;
    logic [0:15]     in_data;
    logic [0:1]      in_keep;
    logic            in_last;
    logic            out_ready;
    logic            s_axis_tready;
    logic [0:15]     m_axis_tdata;
    logic [0:1]      m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tvalid;
    logic [ADDR_W:0] frames_pending;
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
    logic [15:0]     drop_count;
`endif

    always #5 aclk = ~aclk;

    dnpcie_aurora_txframer dut (
        .aclk           (aclk),
        .reset          (rst),
        .channel_up     (cu),
        .s_axis_tdata   (in_data),
        .s_axis_tkeep   (in_keep),
        .s_axis_tlast   (in_last),
        .s_axis_tvalid  (in_valid),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (out_ready),
        .frames_pending (frames_pending)
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    typedef struct {
        int         len;
        logic [1:0] lkeep;
        int         exp_out;
        int         exp_peak;
    } fcase_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          out_cnt  = 0;
    int          peak     = 0;
    int          last_in_cyc = 0;
    int          exp_pending = 0;
    int          smp_cyc  = 0;
    logic        smp_tvalid = 1'b0;
    logic        smp_tlast  = 1'b0;
    logic        smp_in_fire = 1'b0;
    logic [18:0] smp_word = '0;
    logic [18:0] outq[$];
    logic [18:0] cur[$];
    logic        discarding = 1'b0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // One clock: sample mid-cycle, check against the model, advance the model, then check registered state
    task automatic tick();
        logic        in_fire;
        logic        out_fire;
        logic        commit;
        logic        exp_tready;
        logic [18:0] word;
        logic [18:0] w;
        #1;
        commit     = 1'b0;
        word       = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        smp_word   = word;
        smp_cyc    = cyc;
        smp_tvalid = m_axis_tvalid;
        smp_tlast  = m_axis_tlast;
        exp_tready = rst ? 1'b0 : (!cu ? 1'b1 : ((outq.size() + cur.size()) < DEPTH));
        chk("s_tready", 32'(s_axis_tready), 32'(exp_tready));
        in_fire     = in_valid && s_axis_tready;
        out_fire    = m_axis_tvalid && out_ready;
        smp_in_fire = in_fire;
        if (in_fire) last_in_cyc = cyc;
        if (prev_stall) chk("stall_hold", 32'({m_axis_tvalid, word}), 32'({1'b1, prev_word}));
        if (m_axis_tvalid) chk("valid_has_word", 32'(outq.size() != 0), 32'd1);
        if (out_fire && outq.size() != 0) begin
            w = outq.pop_front();
            chk("out_word", 32'(word), 32'(w));
            out_cnt++;
        end
        prev_stall = !rst && cu && m_axis_tvalid && !out_ready;
        prev_word  = word;
        if (rst) begin
            outq.delete(); cur.delete(); discarding = 1'b0; exp_pending = 0;
        end else if (!cu) begin
            discarding = discarding || (cur.size() != 0);
            outq.delete(); cur.delete(); exp_pending = 0;
        end else begin
            if (in_fire) begin
                if (discarding) begin
                    if (in_last) discarding = 1'b0;
                end else if (cur.size() == MAXW) begin
                    cur.delete();
                    discarding = !in_last;
                end else begin
                    cur.push_back({in_data, in_keep, in_last});
                    if (in_last) begin
                        foreach (cur[i]) outq.push_back(cur[i]);
                        cur.delete();
                        commit = 1'b1;
                    end
                end
            end
            exp_pending = exp_pending + int'(commit) - int'(out_fire && m_axis_tlast);
        end
        @(posedge aclk);
        #1;
        cyc++;
        chk("frames_pending", 32'(frames_pending), 32'(exp_pending));
        if (int'(frames_pending) > peak) peak = int'(frames_pending);
    endtask

    task automatic send(input logic [15:0] d, input logic [1:0] k, input logic l);
        int budget;
        budget   = 300;
        in_valid = 1'b1; in_data = d; in_keep = k; in_last = l;
        do begin
            tick();
            budget--;
        end while (!smp_in_fire && budget > 0);
        chk("send_accept", 32'(smp_in_fire), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [1:0] lkeep);
        for (int i = 0; i < len; i++) begin
            send(16'($urandom), (i == len - 1) ? lkeep : 2'b11, i == len - 1);
        end
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (outq.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("drain_done", 32'(outq.size()), 32'd0);
        repeat (3) tick();
    endtask

    task automatic wait_valid();
        int budget;
        budget = 20;
        do begin
            tick();
            budget--;
        end while (!smp_tvalid && budget > 0);
        chk("wait_valid", 32'(smp_tvalid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fcase_t cases[8];
        int     base;
        int     budget;
        int     n;
        int     quiet;
        int     rem;
        int     low;
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        logic [15:0] d0;
`endif
        cases[0] = '{1,  2'b11, 1,  1};
        cases[1] = '{2,  2'b10, 2,  1};
        cases[2] = '{3,  2'b11, 3,  1};
        cases[3] = '{31, 2'b11, 31, 1};
        cases[4] = '{32, 2'b11, 32, 1};
        cases[5] = '{33, 2'b11, 0,  0};
        cases[6] = '{40, 2'b11, 0,  0};
        cases[7] = '{5,  2'b10, 5,  1};

        rst = 1'b1; cu = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
        out_ready = 1'b0;
        @(posedge aclk);
        #1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
        chk("rst_tkeep", 32'(m_axis_tkeep), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        chk("rst_pending", 32'(frames_pending), 32'd0);
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        chk("rst_drops", 32'(drop_count), 32'd0);
`endif

        // Frame-length table
        foreach (cases[i]) begin
            out_ready = 1'b1;
            base = out_cnt;
            peak = 0;
            send_frame(cases[i].len, cases[i].lkeep);
            drain(200);
            chk("case_words", 32'(out_cnt - base), 32'(cases[i].exp_out));
            chk("case_peak", 32'(peak), 32'(cases[i].exp_peak));
        end

        // Oversize frame followed by a 2-word frame
        base = out_cnt;
        peak = 0;
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        d0 = drop_count;
`endif
        send_frame(33, 2'b11);
        send_frame(2, 2'b11);
        drain(200);
        chk("ovs_out", 32'(out_cnt - base), 32'd2);
        chk("ovs_peak", 32'(peak), 32'd1);
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        chk("ovs_drops", 32'(drop_count), 32'(d0 + 16'd1));
`endif

        // Latency and contiguity of a 3-word frame
        out_ready = 1'b1;
        send(16'hA001, 2'b11, 1'b0);
        send(16'hA002, 2'b11, 1'b0);
        send(16'hA003, 2'b11, 1'b1);
        n = last_in_cyc;
        wait_valid();
        chk("lat_cycles", 32'(smp_cyc - n), 32'd2);
        chk("lat_first_data", 32'(smp_word), 32'({16'hA001, 2'b11, 1'b0}));
        tick();
        chk("contig_2", 32'(smp_tvalid), 32'd1);
        tick();
        chk("contig_3", 32'(smp_tvalid), 32'd1);
        chk("contig_3_last", 32'(smp_tlast), 32'd1);
        drain(50);

        // Fill with 64 one-word frames while output is stalled
        out_ready = 1'b0;
        base = out_cnt;
        for (int i = 0; i < 64; i++) send(16'(16'h1000 + i), 2'b11, 1'b1);
        chk("full_tready", 32'(s_axis_tready), 32'd0);
        chk("full_pending", 32'(frames_pending), 32'd64);
        in_valid = 1'b1; in_data = 16'hFFFF; in_keep = 2'b11; in_last = 1'b1;
        tick();
        chk("full_stall", 32'(smp_in_fire), 32'd0);
        in_valid = 1'b0;
        drain(300);
        chk("full_out", 32'(out_cnt - base), 32'd64);
        chk("full_drained", 32'(frames_pending), 32'd0);

        // Link loss while frame 2 of 3 is mid-output
        out_ready = 1'b0;
        base = out_cnt;
        for (int f = 0; f < 3; f++) send_frame(4, 2'b11);
        out_ready = 1'b1;
        budget = 50;
        while ((out_cnt - base) < 5 && budget > 0) begin
            tick();
            budget--;
        end
        chk("flush_setup", 32'(out_cnt - base), 32'd5);
        cu = 1'b0;
        tick();
        chk("flush_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("flush_pending", 32'(frames_pending), 32'd0);
        tick();
        tick();
        cu = 1'b1;
        quiet = 0;
        repeat (6) begin
            tick();
            if (smp_tvalid) quiet++;
        end
        chk("flush_quiet", 32'(quiet), 32'd0);
        base = out_cnt;
        send_frame(2, 2'b11);
        drain(50);
        chk("post_flush_out", 32'(out_cnt - base), 32'd2);

        // Partial last word held through a 5-cycle stall
        out_ready = 1'b0;
        send(16'h5A5A, 2'b11, 1'b0);
        send(16'hB7B7, 2'b10, 1'b1);
        wait_valid();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("stall_valid", 32'(smp_tvalid), 32'd1);
            chk("stall_word", 32'(smp_word), 32'({16'hB7B7, 2'b10, 1'b1}));
        end
        drain(20);

        // Reset with a frame on the output and another half stored
        out_ready = 1'b0;
        send_frame(2, 2'b11);
        wait_valid();
        send(16'h0101, 2'b11, 1'b0);
        send(16'h0202, 2'b11, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst2_word", 32'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 32'd0);
        chk("rst2_pending", 32'(frames_pending), 32'd0);
`ifdef DNPCIE_AURORA_TXFRAMER_STATS_EN
        chk("rst2_drops", 32'(drop_count), 32'd0);
`endif
        out_ready = 1'b1;
        base = out_cnt;
        send_frame(3, 2'b11);
        drain(50);
        chk("post_rst_out", 32'(out_cnt - base), 32'd3);

        // Random traffic with backpressure, oversize frames and link drops
        rem = 0;
        low = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            if (low == 0 && !(in_valid && !smp_in_fire) && $urandom_range(0, 149) == 0) begin
                low = int'($urandom_range(1, 6));
            end
            if (low > 0) begin
                low--;
                cu = 1'b0;
                in_valid = 1'b0;
            end else begin
                cu = 1'b1;
                if (!(in_valid && !smp_in_fire)) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    if (in_valid) begin
                        if (rem == 0) rem = int'($urandom_range(1, 40));
                        in_data = 16'($urandom);
                        in_last = (rem == 1);
                        in_keep = (rem == 1 && $urandom_range(0, 1) == 1) ? 2'b10 : 2'b11;
                    end
                end
            end
            tick();
            if (smp_in_fire) rem--;
        end
        cu = 1'b1;
        drain(1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
